// File: rtl/vproc_opfetch_seq_if.sv
// Dispatcher-to-sequencer and sequencer-to-operand-fetch signal bundle.
// fetch_info packing (MSB..LSB): vreg, elemwise, base_addr[4:0], vreg_addr[4:0],
// fetch, shift, narrow.  store_info packing: vreg, shift.
interface vproc_opfetch_seq_if #(
  parameter int unsigned PART_W = 3
);
  logic              flush_i;
  logic              instr_valid_i;
  logic              instr_ready_o;
  logic [1:0]        instr_emul_i;
  logic [1:0]        instr_widenarrow_i;
  logic              instr_rs1_vreg_i;
  logic [4:0]        instr_rs1_addr_i;
  logic              instr_rs2_vreg_i;
  logic [4:0]        instr_rs2_addr_i;
  logic              instr_rd_vreg_i;
  logic [4:0]        instr_rd_addr_i;
  logic [31:0]       pend_vreg_i;
  logic              op_valid_o;
  logic              op_ready_i;
  logic              op_first_o;
  logic              op_last_o;
  logic [PART_W-1:0] op_part_o;
  logic [14:0]       op_rs1_o;
  logic [14:0]       op_rs2_o;
  logic [1:0]        op_rd_o;
  logic [4:0]        op_rd_addr_o;

  modport master (
    output flush_i, instr_valid_i, instr_emul_i, instr_widenarrow_i,
           instr_rs1_vreg_i, instr_rs1_addr_i, instr_rs2_vreg_i, instr_rs2_addr_i,
           instr_rd_vreg_i, instr_rd_addr_i, pend_vreg_i, op_ready_i,
    input  instr_ready_o, op_valid_o, op_first_o, op_last_o, op_part_o,
           op_rs1_o, op_rs2_o, op_rd_o, op_rd_addr_o
  );

  modport slave (
    input  flush_i, instr_valid_i, instr_emul_i, instr_widenarrow_i,
           instr_rs1_vreg_i, instr_rs1_addr_i, instr_rs2_vreg_i, instr_rs2_addr_i,
           instr_rd_vreg_i, instr_rd_addr_i, pend_vreg_i, op_ready_i,
    output instr_ready_o, op_valid_o, op_first_o, op_last_o, op_part_o,
           op_rs1_o, op_rs2_o, op_rd_o, op_rd_addr_o
  );
endinterface

// File: rtl/vproc_opfetch_seq.sv
// Register-group sequencer: captures one decoded vector instruction, waits
// for its source groups to be free of pending writes, then issues one part
// per cycle with per-part source fetch and destination store information.
module vproc_opfetch_seq #(
  parameter bit          HAZARD_CHECK = 1'b1,
  parameter int unsigned PART_W       = 3
) (
  input  logic                 clk_i,
  input  logic                 sync_rst_i,
  vproc_opfetch_seq_if.slave   bus
);

  localparam logic [1:0] OP_SINGLEWIDTH  = 2'd0;
  localparam logic [1:0] OP_WIDENING     = 2'd1;
  localparam logic [1:0] OP_WIDENING_VS2 = 2'd2;
  localparam logic [1:0] OP_NARROWING    = 2'd3;
  localparam logic [1:0] EMUL_8          = 2'd3;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RUN = 2'd2} state_e;

  typedef struct packed {
    logic       vreg;
    logic       elemwise;
    logic [4:0] base_addr;
    logic [4:0] vreg_addr;
    logic       fetch;
    logic       shift;
    logic       narrow;
  } fetch_info_t;

  typedef struct packed {
    logic vreg;
    logic shift;
  } store_info_t;

  typedef struct packed {
    logic [1:0] emul;
    logic [1:0] widenarrow;
    logic       rs1_vreg;
    logic [4:0] rs1_addr;
    logic       rs2_vreg;
    logic [4:0] rs2_addr;
    logic       rd_vreg;
    logic [4:0] rd_addr;
  } instr_t;

  state_e            state_q, state_d;
  logic [PART_W-1:0] cnt_q, cnt_d;
  instr_t            instr_q, instr_d, instr_in_s;

  logic [3:0]        parts_s;
  logic [PART_W-1:0] last_part_s;
  logic              rs1_half_s, rs2_half_s;
  logic [3:0]        rs1_cnt_s, rs2_cnt_s;
  logic [31:0]       read_mask_s;
  logic              run_s, part_hs_s, done_s;

  // Per-part source info; half-rate sources advance one register every two parts.
  function automatic fetch_info_t src_info(input logic vreg, input logic [4:0] base,
                                           input logic half, input logic [PART_W-1:0] c);
    fetch_info_t info;
    info.vreg      = vreg;
    info.elemwise  = 1'b0;
    info.base_addr = base;
    if (half) begin
      info.vreg_addr = base | 5'(c >> 1);
      info.fetch     = vreg & ~c[0];
      info.shift     = c[0];
      info.narrow    = 1'b1;
    end else begin
      info.vreg_addr = base | 5'(c);
      info.fetch     = vreg;
      info.shift     = 1'b0;
      info.narrow    = 1'b0;
    end
    return info;
  endfunction

  // Pack the offered instruction fields for capture.
  always_comb begin
    instr_in_s.emul       = bus.instr_emul_i;
    instr_in_s.widenarrow = bus.instr_widenarrow_i;
    instr_in_s.rs1_vreg   = bus.instr_rs1_vreg_i;
    instr_in_s.rs1_addr   = bus.instr_rs1_addr_i;
    instr_in_s.rs2_vreg   = bus.instr_rs2_vreg_i;
    instr_in_s.rs2_addr   = bus.instr_rs2_addr_i;
    instr_in_s.rd_vreg    = bus.instr_rd_vreg_i;
    instr_in_s.rd_addr    = bus.instr_rd_addr_i;
  end

  // Part count, half-rate selection and number of registers each source reads.
  always_comb begin
    if (instr_q.widenarrow == OP_SINGLEWIDTH) begin
      parts_s = 4'd1 << instr_q.emul;
    end else if (instr_q.emul == EMUL_8) begin
      parts_s = 4'd8;  // illegal combination, clamp to the largest group
    end else begin
      parts_s = 4'd2 << instr_q.emul;
    end
    last_part_s = PART_W'(parts_s - 4'd1);
    rs1_half_s  = (instr_q.widenarrow == OP_WIDENING) ||
                  (instr_q.widenarrow == OP_WIDENING_VS2) ||
                  (instr_q.widenarrow == OP_NARROWING);
    rs2_half_s  = (instr_q.widenarrow == OP_WIDENING);
    rs1_cnt_s   = rs1_half_s ? (parts_s >> 1) : parts_s;
    rs2_cnt_s   = rs2_half_s ? (parts_s >> 1) : parts_s;
  end

  // Registers read by the vector sources; the destination group is excluded.
  always_comb begin
    read_mask_s = 32'd0;
    for (int k = 0; k < 8; k++) begin
      if (instr_q.rs1_vreg && (4'(k) < rs1_cnt_s)) begin
        read_mask_s[instr_q.rs1_addr | 5'(k)] = 1'b1;
      end
      if (instr_q.rs2_vreg && (4'(k) < rs2_cnt_s)) begin
        read_mask_s[instr_q.rs2_addr | 5'(k)] = 1'b1;
      end
    end
  end

  // Next-state, part counter and instruction capture; flush overrides everything.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    instr_d           = instr_q;
    bus.instr_ready_o = 1'b0;
    run_s             = (state_q == ST_RUN);
    part_hs_s         = run_s & bus.op_ready_i;
    done_s            = part_hs_s & (cnt_q == last_part_s);
    if (bus.flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      instr_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bus.instr_ready_o = 1'b1;
          if (bus.instr_valid_i) begin
            instr_d = instr_in_s;
            cnt_d   = '0;
            state_d = HAZARD_CHECK ? ST_WAIT : ST_RUN;
          end
        end
        ST_WAIT: begin
          if ((bus.pend_vreg_i & read_mask_s) == 32'd0) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (done_s) begin
            bus.instr_ready_o = 1'b1;
            cnt_d             = '0;
            if (bus.instr_valid_i) begin
              instr_d = instr_in_s;
              state_d = HAZARD_CHECK ? ST_WAIT : ST_RUN;
            end else begin
              instr_d = '0;
              state_d = ST_IDLE;
            end
          end else if (part_hs_s) begin
            cnt_d = cnt_q + PART_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          instr_d = '0;
        end
      endcase
    end
  end

  // Part outputs decoded from registered state; all zero outside RUN.
  always_comb begin
    fetch_info_t rs1_s, rs2_s;
    store_info_t rd_s;
    logic [4:0]  rd_addr_s;
    rs1_s = src_info(instr_q.rs1_vreg, instr_q.rs1_addr, rs1_half_s, cnt_q);
    rs2_s = src_info(instr_q.rs2_vreg, instr_q.rs2_addr, rs2_half_s, cnt_q);
    if (instr_q.widenarrow == OP_NARROWING) begin
      rd_addr_s  = instr_q.rd_addr | 5'(cnt_q >> 1);
      rd_s.vreg  = instr_q.rd_vreg & cnt_q[0];
      rd_s.shift = ~cnt_q[0];
    end else begin
      rd_addr_s  = instr_q.rd_addr | 5'(cnt_q);
      rd_s.vreg  = instr_q.rd_vreg;
      rd_s.shift = 1'b0;
    end
    if (state_q == ST_RUN) begin
      bus.op_valid_o   = 1'b1;
      bus.op_first_o   = (cnt_q == '0);
      bus.op_last_o    = (cnt_q == last_part_s);
      bus.op_part_o    = cnt_q;
      bus.op_rs1_o     = rs1_s;
      bus.op_rs2_o     = rs2_s;
      bus.op_rd_o      = rd_s;
      bus.op_rd_addr_o = rd_addr_s;
    end else begin
      bus.op_valid_o   = 1'b0;
      bus.op_first_o   = 1'b0;
      bus.op_last_o    = 1'b0;
      bus.op_part_o    = '0;
      bus.op_rs1_o     = 15'd0;
      bus.op_rs2_o     = 15'd0;
      bus.op_rd_o      = 2'd0;
      bus.op_rd_addr_o = 5'd0;
    end
  end

  // State, counter and captured instruction registers.
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: tb/tb_vproc_opfetch_seq.sv
// Directed testbench for vproc_opfetch_seq with hand-computed part sequences.
module tb_vproc_opfetch_seq;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  vproc_opfetch_seq_if #(.PART_W(3)) bus ();

  vproc_opfetch_seq #(.HAZARD_CHECK(1'b1), .PART_W(3)) dut (
    .clk_i      (clk),
    .sync_rst_i (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected fetch_info word: vreg, elemwise=0, base, addr, fetch, shift, narrow.
  function automatic logic [14:0] fi(input logic v, input logic [4:0] b, input logic [4:0] a,
                                     input logic f, input logic s, input logic n);
    return {v, 1'b0, b, a, f, s, n};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [1:0] emul, input logic [1:0] wn,
                           input logic v1, input logic [4:0] a1,
                           input logic v2, input logic [4:0] a2,
                           input logic vd, input logic [4:0] ad);
    bus.instr_emul_i       = emul;
    bus.instr_widenarrow_i = wn;
    bus.instr_rs1_vreg_i   = v1;
    bus.instr_rs1_addr_i   = a1;
    bus.instr_rs2_vreg_i   = v2;
    bus.instr_rs2_addr_i   = a2;
    bus.instr_rd_vreg_i    = vd;
    bus.instr_rd_addr_i    = ad;
  endtask

  // Offer the currently set instruction from IDLE; it is accepted on the next edge.
  task automatic offer(input string tag);
    bus.instr_valid_i = 1'b1;
    #2;
    check({tag, "_rdy"}, 32'(bus.instr_ready_o), 32'd1);
    next_cycle();
    bus.instr_valid_i = 1'b0;
  endtask

  task automatic chk_part(input string t, input int c, input logic first, input logic last,
                          input logic [14:0] rs1, input logic [14:0] rs2,
                          input logic [1:0] rd, input logic [4:0] rda);
    check($sformatf("%s_p%0d_valid", t, c), 32'(bus.op_valid_o), 32'd1);
    check($sformatf("%s_p%0d_first", t, c), 32'(bus.op_first_o), 32'(first));
    check($sformatf("%s_p%0d_last", t, c), 32'(bus.op_last_o), 32'(last));
    check($sformatf("%s_p%0d_part", t, c), 32'(bus.op_part_o), 32'(c));
    check($sformatf("%s_p%0d_rs1", t, c), 32'(bus.op_rs1_o), 32'(rs1));
    check($sformatf("%s_p%0d_rs2", t, c), 32'(bus.op_rs2_o), 32'(rs2));
    check($sformatf("%s_p%0d_rd", t, c), 32'(bus.op_rd_o), 32'(rd));
    check($sformatf("%s_p%0d_rda", t, c), 32'(bus.op_rd_addr_o), 32'(rda));
  endtask

  task automatic chk_idle(input string t);
    check({t, "_valid"}, 32'(bus.op_valid_o), 32'd0);
    check({t, "_ops"}, 32'({bus.op_first_o, bus.op_last_o, bus.op_part_o,
                            bus.op_rd_o, bus.op_rd_addr_o}), 32'd0);
    check({t, "_rs"}, 32'({bus.op_rs1_o, bus.op_rs2_o}), 32'd0);
  endtask

  // EMUL_8 combined with a non-singlewidth mode must never be offered.
  always @(negedge clk) begin
    if (!rst && bus.instr_valid_i && bus.instr_ready_o)
      check("emul8_legal", 32'((bus.instr_emul_i == 2'd3) && (bus.instr_widenarrow_i != 2'd0)), 32'd0);
  end

  initial begin
    rst = 1'b1;
    bus.flush_i = 1'b0;
    bus.instr_valid_i = 1'b0;
    bus.pend_vreg_i = 32'd0;
    bus.op_ready_i = 1'b1;
    set_instr(2'd0, 2'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Reset state
    #2;
    chk_idle("rst");
    check("rst_rdy", 32'(bus.instr_ready_o), 32'd1);
    next_cycle();

    // SINGLEWIDTH EMUL_4: vs1=v12, vs2=v8, vd=v16 -> 4 parts, then back-to-back WIDENING
    set_instr(2'd2, 2'd0, 1'b1, 5'd12, 1'b1, 5'd8, 1'b1, 5'd16);
    offer("t2");
    #2;
    chk_idle("t2_wait");
    check("t2_wait_rdy", 32'(bus.instr_ready_o), 32'd0);
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        set_instr(2'd1, 2'd1, 1'b1, 5'd6, 1'b1, 5'd4, 1'b1, 5'd8);
        bus.instr_valid_i = 1'b1;
      end
      #2;
      chk_part("t2", c, c == 0, c == 3, fi(1'b1, 5'd12, 5'(12 + c), 1'b1, 1'b0, 1'b0),
               fi(1'b1, 5'd8, 5'(8 + c), 1'b1, 1'b0, 1'b0), 2'b10, 5'(16 + c));
      if (c == 3) check("t2_b2b_rdy", 32'(bus.instr_ready_o), 32'd1);
      next_cycle();
    end
    bus.instr_valid_i = 1'b0;

    // WIDENING EMUL_2: vs1=v6, vs2=v4 half-rate, vd=v8
    #2;
    chk_idle("t3_wait");
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      logic [4:0] h;
      logic       odd;
      h = 5'(c / 2);
      odd = (c % 2) == 1;
      #2;
      chk_part("t3", c, c == 0, c == 3, fi(1'b1, 5'd6, 5'd6 + h, ~odd, odd, 1'b1),
               fi(1'b1, 5'd4, 5'd4 + h, ~odd, odd, 1'b1), 2'b10, 5'(8 + c));
      next_cycle();
    end
    #2;
    chk_idle("t3_end");
    check("t3_end_rdy", 32'(bus.instr_ready_o), 32'd1);
    next_cycle();

    // NARROWING EMUL_1: vs1 scalar x3, vs2=v2 full-rate, vd=v1 half-rate
    set_instr(2'd0, 2'd3, 1'b0, 5'd3, 1'b1, 5'd2, 1'b1, 5'd1);
    offer("t4");
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      #2;
      chk_part("t4", c, c == 0, c == 1, fi(1'b0, 5'd3, 5'd3, 1'b0, c == 1, 1'b1),
               fi(1'b1, 5'd2, 5'(2 + c), 1'b1, 1'b0, 1'b0),
               (c == 0) ? 2'b01 : 2'b10, 5'd1);
      next_cycle();
    end

    // Hazard: EMUL_2 vs2=v4 with v5 pending for 5 cycles
    bus.pend_vreg_i = 32'h0000_0020;
    set_instr(2'd1, 2'd0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b1, 5'd12);
    offer("t5");
    for (int i = 0; i < 5; i++) begin
      #2;
      check($sformatf("t5_stall%0d", i), 32'(bus.op_valid_o), 32'd0);
      next_cycle();
    end
    bus.pend_vreg_i = 32'd0;
    #2;
    check("t5_clr_cycle", 32'(bus.op_valid_o), 32'd0);
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      #2;
      chk_part("t5", c, c == 0, c == 1, fi(1'b0, 5'd0, 5'(c), 1'b0, 1'b0, 1'b0),
               fi(1'b1, 5'd4, 5'(4 + c), 1'b1, 1'b0, 1'b0), 2'b10, 5'(12 + c));
      next_cycle();
    end

    // Unrelated pending v6 (vd group and scalar vs1 index) must not stall
    bus.pend_vreg_i = 32'h0000_0040;
    set_instr(2'd1, 2'd0, 1'b0, 5'd6, 1'b1, 5'd4, 1'b1, 5'd6);
    offer("t5b");
    #2;
    check("t5b_wait", 32'(bus.op_valid_o), 32'd0);
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      #2;
      chk_part("t5b", c, c == 0, c == 1, fi(1'b0, 5'd6, 5'(6 + c), 1'b0, 1'b0, 1'b0),
               fi(1'b1, 5'd4, 5'(4 + c), 1'b1, 1'b0, 1'b0), 2'b10, 5'(6 + c));
      next_cycle();
    end
    bus.pend_vreg_i = 32'd0;

    // Stall in part 1 for 3 cycles, then flush while a new instruction is offered
    set_instr(2'd1, 2'd0, 1'b1, 5'd20, 1'b1, 5'd22, 1'b1, 5'd24);
    offer("t6");
    next_cycle();
    #2;
    chk_part("t6", 0, 1'b1, 1'b0, fi(1'b1, 5'd20, 5'd20, 1'b1, 1'b0, 1'b0),
             fi(1'b1, 5'd22, 5'd22, 1'b1, 1'b0, 1'b0), 2'b10, 5'd24);
    next_cycle();
    bus.op_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk_part($sformatf("t6_hold%0d", i), 1, 1'b0, 1'b1, fi(1'b1, 5'd20, 5'd21, 1'b1, 1'b0, 1'b0),
               fi(1'b1, 5'd22, 5'd23, 1'b1, 1'b0, 1'b0), 2'b10, 5'd25);
      next_cycle();
    end
    bus.flush_i = 1'b1;
    set_instr(2'd0, 2'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1, 5'd5);
    bus.instr_valid_i = 1'b1;
    #2;
    check("t6_flush_rdy", 32'(bus.instr_ready_o), 32'd0);
    next_cycle();
    bus.flush_i = 1'b0;
    bus.instr_valid_i = 1'b0;
    bus.op_ready_i = 1'b1;
    #2;
    chk_idle("t6_post");
    check("t6_post_rdy", 32'(bus.instr_ready_o), 32'd1);
    next_cycle();
    offer("t6n");
    next_cycle();
    #2;
    chk_part("t6n", 0, 1'b1, 1'b1, fi(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0),
             fi(1'b1, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0), 2'b10, 5'd5);
    next_cycle();
    #2;
    chk_idle("t6n_end");
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vproc_opfetch_seq.md
Name: vproc_opfetch_seq

Overview:
- Per-instruction register-group sequencer between the dispatcher and the unit operand-fetch stage.
- Accepts one decoded instruction (EMUL, width mode, vs1/vs2/vd) and waits until no source register is pending write.
- Then emits one "part" per cycle: vs1/vs2 as fetch_info, vd as store_info plus address, each with first/last flags.
- Downstream units use each part to read the register file and write back one vector register.

Parameters:
HAZARD_CHECK, 1, 1: stall on pending-write sources; 0: skip WAIT state.
PART_W, 3, width of part counter (max 8 parts).

Ports:
clk_i  in  1  clock
sync_rst_i  in  1  synchronous active-high reset
flush_i  in  1  abort current instruction
instr_valid_i  in  1  instruction offered
instr_ready_o  out  1  instruction accepted when valid&ready
instr_emul_i  in  2  cfg_emul of the instruction
instr_widenarrow_i  in  2  op_widenarrow
instr_rs1_vreg_i  in  1  vs1 is a vector register
instr_rs1_addr_i  in  5  vs1 base
instr_rs2_vreg_i  in  1  vs2 is a vector register
instr_rs2_addr_i  in  5  vs2 base
instr_rd_vreg_i  in  1  vd is a vector register
instr_rd_addr_i  in  5  vd base
pend_vreg_i  in  32  per-register pending-write mask
op_valid_o  out  1  part valid
op_ready_i  in  1  part consumed
op_first_o  out  1  first part
op_last_o  out  1  last part
op_part_o  out  PART_W  part index
op_rs1_o  out  fetch_info  vs1 fetch info
op_rs2_o  out  fetch_info  vs2 fetch info
op_rd_o  out  store_info  vd store info
op_rd_addr_o  out  5  vd register this part

Behaviour:
- Interface: one clock clk_i; reset sync_rst_i is synchronous and active-high.
- Reset/flush: state IDLE, counter 0, captured instruction cleared. op_valid_o=0. All op_* outputs are 0 whenever op_valid_o=0. flush_i has priority over all events and drops any in-flight part.
- FSM IDLE -> WAIT -> RUN.
  - IDLE: instr_ready_o=1. A handshake latches all instr_* fields.
  - Next state is WAIT if HAZARD_CHECK=1, else RUN.
- Part count: base N = 1<<emul.
  - OP_SINGLEWIDTH: P=N.
  - OP_WIDENING, OP_WIDENING_VS2, OP_NARROWING: P=2N.
  - EMUL_8 with a non-singlewidth mode is illegal. It clamps to P=8; the bench asserts it never occurs.
- Read mask: for each vector source, the bits {base | k} over the register indices that source reads.
  - Scalar sources contribute nothing.
- WAIT: stay while (pend_vreg_i & read mask) != 0. Move to RUN in the cycle after the mask clears. pend_vreg_i is sampled every cycle.
- RUN: op_valid_o=1, c = part counter.
  - op_first_o = (c==0); op_last_o = (c==P-1); op_part_o = c.
  - Counter advances only on op_valid_o & op_ready_i. If ready is low, all outputs hold stable.
- Source fields for each vs (fetch_info):
  - vreg = instr vreg flag; base_addr = instr base.
  - elemwise = 0.
  - If the source is "half-rate", vreg_addr = base | (c>>1), fetch = vreg & ~c[0], shift = c[0], narrow = 1.
  - Otherwise vreg_addr = base | c, fetch = vreg, shift = 0, narrow = 0.
- Half-rate sources by mode:
  - WIDENING: vs1 and vs2.
  - WIDENING_VS2: vs1 only.
  - NARROWING: vs1 only.
  - SINGLEWIDTH: none.
- Destination fields:
  - NARROWING: op_rd_addr_o = rd | (c>>1), op_rd_o.vreg = rd_vreg & c[0], shift = ~c[0].
  - All other modes: op_rd_addr_o = rd | c, vreg = rd_vreg, shift = 0.
- End of instruction: a handshake on the last part returns to IDLE. instr_ready_o is also 1 in that same cycle (back-to-back).
  - A new instruction accepted then goes to WAIT/RUN with no idle bubble, counter 0.
- Latency, instruction accept to first op_valid_o: 2 cycles with HAZARD_CHECK=1 and no hazard; 1 cycle with HAZARD_CHECK=0.
- Counter never wraps: P-1 is the terminal value and is reached only in RUN.
- The vd group is not part of the hazard check (WAW is handled downstream).
- flush_i in the same cycle as instr_valid_i: the instruction is not accepted, instr_ready_o=0.

Test Plan:
- Reset, then no instruction -> op_valid_o=0, instr_ready_o=1, all op_* = 0.
- SINGLEWIDTH, EMUL_4, vs2=v8, vs1=v12, vd=v16, pend=0, ready=1 -> 4 parts, addresses 8..11 / 12..15 / 16..19, first on part 0, last on part 3, fetch=1 each, shift=0.
- WIDENING, EMUL_2, vs2=v4, vs1=v6, vd=v8 -> 4 parts. Source addresses 4,4,5,5 and 6,6,7,7. fetch 1,0,1,0; shift 0,1,0,1; narrow=1. vd addresses 8..11, all vreg=1.
- NARROWING, EMUL_1, vs2=v2, vd=v1 -> 2 parts. vs2 addresses 2,3 full-rate. vd address 1 both parts, store vreg 0 then 1, shift 1 then 0.
- EMUL_2, vs2=v4, pend_vreg_i=0x20 for 5 cycles then 0 -> stays in WAIT 5 cycles, first part 1 cycle after clear. pend=0x40 (unrelated) -> no stall.
- op_ready_i held low 3 cycles in part 1, then flush_i -> outputs stable while stalled. After flush: IDLE, op_valid_o=0, next instruction starts at part 0.
